// File: rtl/dca_matrix_row_sender_pkg.sv
`default_nettype none
// ============================================================================
// dca_matrix_row_sender_pkg : shared dca matrix widths and sender state encoding
// Revision 1.0
// ============================================================================
package dca_matrix_row_sender_pkg;

  localparam int BW_MATRIX_COUNT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  function automatic int bw_tensor_row(input int ms, input int bw_scalar);
    return ms * bw_scalar;
  endfunction

  function automatic int bw_row_num(input int ms);
    return $clog2(ms) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dca_row_skid_buffer.sv
`default_nettype none
// ============================================================================
// dca_row_skid_buffer : two-entry row FIFO, push and pop may share a cycle
// Revision 1.0
// ============================================================================
module dca_row_skid_buffer #(
  parameter int BW_DATA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_pop,
  output logic [BW_DATA-1:0] o_head,
  output logic               o_empty,
  output logic               o_full
);

  logic [BW_DATA-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);

endmodule
`default_nettype wire

// File: rtl/dca_matrix_row_sender.sv
`default_nettype none
// ============================================================================
// dca_matrix_row_sender : forwards up to MS source rows per command, zero-pads to MS
// Revision 1.0
// ============================================================================
module dca_matrix_row_sender
  import dca_matrix_row_sender_pkg::*;
#(
  parameter int                         MATRIX_SIZE_PARA    = 8,
  parameter int                         BW_TENSOR_SCALAR    = 32,
  parameter logic [BW_MATRIX_COUNT-1:0] MATRIX_COUNT_PRESET = '0,
  localparam int BW_TENSOR_ROW = bw_tensor_row(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR),
  localparam int BW_ROW_NUM    = bw_row_num(MATRIX_SIZE_PARA)
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic                       clear,
  input  logic                       enable,
  output logic                       busy,
  input  logic                       cmd_wvalid,
  output logic                       cmd_wready,
  input  logic [BW_ROW_NUM-1:0]      cmd_num_rows,
  input  logic                       src_row_wvalid,
  output logic                       src_row_wready,
  input  logic [BW_TENSOR_ROW-1:0]   src_row_wdata,
  output logic                       load_tensor_row_wvalid,
  input  logic                       load_tensor_row_wready,
  output logic                       load_tensor_row_wlast,
  output logic [BW_TENSOR_ROW-1:0]   load_tensor_row_wdata,
  output logic [BW_MATRIX_COUNT-1:0] matrix_count
);

  localparam logic [BW_ROW_NUM-1:0] c_MS  = BW_ROW_NUM'(MATRIX_SIZE_PARA);
  localparam logic [BW_ROW_NUM-1:0] c_ONE = BW_ROW_NUM'(1);

  state_t                     r_state, w_state_nxt;
  logic [BW_ROW_NUM-1:0]      r_n, w_n_nxt;
  logic [BW_ROW_NUM-1:0]      r_row_idx, w_row_idx_nxt;
  logic [BW_ROW_NUM-1:0]      r_accepted, w_accepted_nxt;
  logic [BW_ROW_NUM-1:0]      w_n_clamped;
  logic [BW_MATRIX_COUNT-1:0] r_matrix_count;
  logic [BW_TENSOR_ROW-1:0]   w_head;
  logic                       w_go, w_src_fire, w_out_fire, w_pop;
  logic                       w_buf_empty, w_buf_full;

  // Reset and clear mask every handshake in the cycle they are asserted.
  assign w_go        = enable && !rstnn && !clear;
  assign w_n_clamped = (cmd_num_rows > c_MS) ? c_MS : cmd_num_rows;
  assign w_src_fire  = src_row_wvalid && src_row_wready;
  assign w_out_fire  = load_tensor_row_wvalid && load_tensor_row_wready;
  assign w_pop       = w_out_fire && (r_state == ST_SEND);

  dca_row_skid_buffer #(
    .BW_DATA (BW_TENSOR_ROW)
  ) u_skid (
    .clk     (clk),
    .rst     (rstnn),
    .i_flush (clear),
    .i_push  (w_src_fire),
    .i_data  (src_row_wdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_buf_empty),
    .o_full  (w_buf_full)
  );

  always_ff @(posedge clk) begin
    if (rstnn || clear) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_row_idx  <= '0;
      r_accepted <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_n        <= w_n_nxt;
      r_row_idx  <= w_row_idx_nxt;
      r_accepted <= w_accepted_nxt;
    end
  end

  always_comb begin
    w_state_nxt            = r_state;
    w_n_nxt                = r_n;
    w_row_idx_nxt          = r_row_idx;
    w_accepted_nxt         = r_accepted;
    cmd_wready             = 1'b0;
    src_row_wready         = 1'b0;
    load_tensor_row_wvalid = 1'b0;
    load_tensor_row_wdata  = '0;
    unique case (r_state)
      ST_IDLE: begin
        cmd_wready = w_go;
        if (cmd_wvalid && w_go) begin
          w_n_nxt        = w_n_clamped;
          w_row_idx_nxt  = '0;
          w_accepted_nxt = '0;
          w_state_nxt    = (w_n_clamped != '0) ? ST_SEND : ST_PAD;
        end
      end
      ST_SEND: begin
        src_row_wready         = w_go && !w_buf_full && (r_accepted < r_n);
        load_tensor_row_wvalid = w_go && !w_buf_empty;
        if (!w_buf_empty) load_tensor_row_wdata = w_head;
        if (src_row_wvalid && w_go && !w_buf_full && (r_accepted < r_n))
          w_accepted_nxt = r_accepted + c_ONE;
        if (w_go && !w_buf_empty && load_tensor_row_wready) begin
          w_row_idx_nxt = r_row_idx + c_ONE;
          if (r_row_idx == r_n - c_ONE) begin
            if (r_n == c_MS) begin
              w_state_nxt   = ST_IDLE;
              w_row_idx_nxt = '0;
            end else begin
              w_state_nxt = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        load_tensor_row_wvalid = w_go;
        if (w_go && load_tensor_row_wready) begin
          if (r_row_idx == c_MS - c_ONE) begin
            w_state_nxt   = ST_IDLE;
            w_row_idx_nxt = '0;
          end else begin
            w_row_idx_nxt = r_row_idx + c_ONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign load_tensor_row_wlast = load_tensor_row_wvalid && (r_row_idx == c_MS - c_ONE);
  assign busy                  = (r_state != ST_IDLE) || !w_buf_empty;

  // Clear keeps the running count; only reset reloads it.
  always_ff @(posedge clk) begin
    if (rstnn) begin
      r_matrix_count <= MATRIX_COUNT_PRESET;
    end else if (w_out_fire && load_tensor_row_wlast) begin
      r_matrix_count <= r_matrix_count + 16'd1;
    end
  end

  assign matrix_count = r_matrix_count;

endmodule
`default_nettype wire
